// File: rtl/calc_ctrl.sv
// calc_ctrl: keypad-entry sequencer that feeds registered operands/operator to a combinational ALU.
// Optional feature macro DIV_ZERO_CHECK_EN: flags divide-by-zero captures on err and locks out keys until clear.
module calc_ctrl #(
    parameter int unsigned MAX_DIGITS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic [15:0] alu_res,
    output logic [15:0] alu_A,
    output logic [15:0] alu_B,
    output logic [3:0]  alu_op,
    output logic [15:0] disp,
    output logic        res_valid,
    output logic        err,
    output logic [1:0]  entry_state
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned KEY_W  = 4;
    localparam int unsigned CNT_W  = $clog2(MAX_DIGITS + 1);

    localparam logic [KEY_W-1:0] OP_ADD  = 4'hA;
    localparam logic [KEY_W-1:0] OP_DIV  = 4'hD;
    localparam logic [KEY_W-1:0] KEY_EQ  = 4'hE;
    localparam logic [KEY_W-1:0] KEY_CLR = 4'hF;

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_RES = 2'b10
    } state_t;

    state_t              state, state_n;
    logic [DATA_W-1:0]   a_n, b_n, disp_n;
    logic [KEY_W-1:0]    op_n;
    logic [CNT_W-1:0]    count, count_n;
    logic                res_valid_n, err_n;

    logic                is_digit_c, is_op_c, cnt_full_c, capture_c;
    logic [DATA_W-1:0]   digit_c, acc_a_c, acc_b_c;

    assign entry_state = state;

    // Key classification and decimal shift-in for whichever operand is being entered.
    assign is_digit_c = (key_code <= 4'd9);
    assign is_op_c    = (key_code >= OP_ADD) && (key_code <= OP_DIV);
    assign cnt_full_c = (count == CNT_W'(MAX_DIGITS));
    assign digit_c    = {(DATA_W - KEY_W)'(0), key_code};
    assign acc_a_c    = alu_A * DATA_W'(10) + digit_c;
    assign acc_b_c    = alu_B * DATA_W'(10) + digit_c;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_A;
            alu_A     <= '0;
            alu_B     <= '0;
            alu_op    <= OP_ADD;
            disp      <= '0;
            res_valid <= 1'b0;
            err       <= 1'b0;
            count     <= '0;
        end else begin
            state     <= state_n;
            alu_A     <= a_n;
            alu_B     <= b_n;
            alu_op    <= op_n;
            disp      <= disp_n;
            res_valid <= res_valid_n;
            err       <= err_n;
            count     <= count_n;
        end
    end

    // Next-state and datapath decode; a capture latches the ALU result as the new A.
    always_comb begin
        state_n     = state;
        a_n         = alu_A;
        b_n         = alu_B;
        op_n        = alu_op;
        disp_n      = disp;
        res_valid_n = 1'b0;
        err_n       = err;
        count_n     = count;
        capture_c   = 1'b0;

        if (key_valid) begin
            if (key_code == KEY_CLR) begin
                state_n = S_A;
                a_n     = '0;
                b_n     = '0;
                op_n    = OP_ADD;
                disp_n  = '0;
                err_n   = 1'b0;
                count_n = '0;
            end else if (!err) begin
                case (state)
                    S_A: begin
                        if (is_digit_c) begin
                            if (!cnt_full_c) begin
                                a_n     = acc_a_c;
                                disp_n  = acc_a_c;
                                count_n = count + CNT_W'(1);
                            end
                        end else if (is_op_c) begin
                            op_n    = key_code;
                            b_n     = '0;
                            count_n = '0;
                            state_n = S_B;
                        end
                    end
                    S_B: begin
                        if (is_digit_c) begin
                            if (!cnt_full_c) begin
                                b_n     = acc_b_c;
                                disp_n  = acc_b_c;
                                count_n = count + CNT_W'(1);
                            end
                        end else if (is_op_c) begin
                            op_n = key_code;
                            if (count != '0) begin
                                capture_c = 1'b1;
                                b_n       = '0;
                                count_n   = '0;
                            end
                        end else if (key_code == KEY_EQ) begin
                            capture_c = 1'b1;
                            state_n   = S_RES;
                        end
                    end
                    S_RES: begin
                        if (is_digit_c) begin
                            a_n     = digit_c;
                            disp_n  = digit_c;
                            count_n = CNT_W'(1);
                            state_n = S_A;
                        end else if (is_op_c) begin
                            op_n    = key_code;
                            b_n     = '0;
                            count_n = '0;
                            state_n = S_B;
                        end else if (key_code == KEY_EQ) begin
                            capture_c = 1'b1;
                        end
                    end
                    default: state_n = S_A;
                endcase

                if (capture_c) begin
                    a_n         = alu_res;
                    disp_n      = alu_res;
                    res_valid_n = 1'b1;
`ifdef DIV_ZERO_CHECK_EN
                    // Divide by zero: report error and park in S_RES with the pending op/B untouched.
                    if ((alu_op == OP_DIV) && (alu_B == '0)) begin
                        err_n   = 1'b1;
                        disp_n  = 16'hFFFF;
                        a_n     = '0;
                        op_n    = alu_op;
                        b_n     = alu_B;
                        count_n = count;
                        state_n = S_RES;
                    end
`else
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_calc_ctrl.sv
// Bench for calc_ctrl: ALU stub, abstract keypad model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_calc_ctrl;

    localparam int unsigned MAXD = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] alu_res;
    logic [15:0] alu_A, alu_B, disp;
    logic [3:0]  alu_op;
    logic        res_valid, err;
    logic [1:0]  entry_state;

    int n_chk  = 0;
    int n_fail = 0;
    int rv_seen = 0;

    always #5 clk = ~clk;

    calc_ctrl #(.MAX_DIGITS(MAXD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .alu_res    (alu_res),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_op     (alu_op),
        .disp       (disp),
        .res_valid  (res_valid),
        .err        (err),
        .entry_state(entry_state)
    );

    // Calculator ALU stand-in.
    function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        case (op)
            4'hA:    return a + b;
            4'hB:    return a - b;
            4'hC:    return a * b;
            4'hD:    return (b == 16'd0) ? 16'hFFFF : a / b;
            default: return 16'd0;
        endcase
    endfunction

    assign alu_res = alu_fn(alu_A, alu_B, alu_op);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = entering A, 1 = entering B, 2 = showing a result.
    logic [15:0] m_a, m_b, m_disp;
    logic [3:0]  m_op;
    int          m_cnt, m_mode;
    bit          m_err, m_rv;

    task automatic model_reset();
        m_a = 16'd0; m_b = 16'd0; m_disp = 16'd0; m_op = 4'hA;
        m_cnt = 0; m_mode = 0; m_err = 1'b0; m_rv = 1'b0;
    endtask

    task automatic model_capture(output bit hit);
        logic [15:0] r;
        hit = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
        if (m_op == 4'hD && m_b == 16'd0) begin
            m_err = 1'b1; m_disp = 16'hFFFF; m_a = 16'd0; m_rv = 1'b1; m_mode = 2;
            hit = 1'b1;
            return;
        end
`endif
        r = alu_fn(m_a, m_b, m_op);
        m_a = r; m_disp = r; m_rv = 1'b1;
    endtask

    task automatic model_step(input bit kv, input logic [3:0] kc);
        bit hit;
        m_rv = 1'b0;
        if (!kv) return;
        if (kc == 4'hF) begin
            model_reset();
        end else if (m_err) begin
            // locked until clear
        end else if (kc <= 4'd9) begin
            if (m_mode == 2) begin
                m_a = {12'd0, kc}; m_disp = m_a; m_cnt = 1; m_mode = 0;
            end else if (m_cnt < MAXD) begin
                m_cnt++;
                if (m_mode == 0) begin m_a = m_a * 16'd10 + {12'd0, kc}; m_disp = m_a; end
                else             begin m_b = m_b * 16'd10 + {12'd0, kc}; m_disp = m_b; end
            end
        end else if (kc == 4'hE) begin
            if (m_mode != 0) begin
                model_capture(hit);
                m_mode = 2;
            end
        end else begin
            if (m_mode == 1 && m_cnt > 0) begin
                model_capture(hit);
                if (!hit) begin m_op = kc; m_b = 16'd0; m_cnt = 0; end
            end else if (m_mode == 1) begin
                m_op = kc;
            end else begin
                m_op = kc; m_b = 16'd0; m_cnt = 0; m_mode = 1;
            end
        end
    endtask

    // Per-cycle compare against the model.
    always @(posedge clk) begin : compare
        bit         kv;
        logic [3:0] kc;
        if (rst_n === 1'b1) begin
            kv = key_valid;
            kc = key_code;
            model_step(kv, kc);
            #1;
            if (rst_n === 1'b1) begin
                chk("alu_A", 32'(alu_A), 32'(m_a));
                chk("alu_B", 32'(alu_B), 32'(m_b));
                chk("alu_op", 32'(alu_op), 32'(m_op));
                chk("disp", 32'(disp), 32'(m_disp));
                chk("res_valid", 32'(res_valid), 32'(m_rv));
                chk("err", 32'(err), 32'(m_err));
                chk("entry_state", 32'(entry_state), 32'(m_mode));
                if (res_valid === 1'b1) rv_seen++;
            end
        end
    end

    task automatic send_key(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clk);
        #2;
        key_valid = 1'b0;
    endtask

    logic [3:0]  ks[8];
    logic [15:0] ds[8];

    task automatic run_seq(input string nm, input int n);
        for (int i = 0; i < n; i++) begin
            send_key(ks[i]);
            chk($sformatf("%s_disp%0d", nm, i), 32'(disp), 32'(ds[i]));
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_A"}, 32'(alu_A), 32'd0);
        chk({nm, "_B"}, 32'(alu_B), 32'd0);
        chk({nm, "_op"}, 32'(alu_op), 32'hA);
        chk({nm, "_disp"}, 32'(disp), 32'd0);
        chk({nm, "_rv"}, 32'(res_valid), 32'd0);
        chk({nm, "_err"}, 32'(err), 32'd0);
        chk({nm, "_state"}, 32'(entry_state), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        model_reset();
        #2 rst_n = 1'b0;
        #21;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        rv_seen = 0;
        ks = '{4'd1, 4'd2, 4'hA, 4'd3, 4'd4, 4'hE, 4'd0, 4'd0};
        ds = '{16'd1, 16'd12, 16'd12, 16'd3, 16'd34, 16'd46, 16'd0, 16'd0};
        run_seq("add", 6);
        chk("add_pulses", 32'(rv_seen), 32'd1);
        chk("add_state", 32'(entry_state), 32'd2);

        rv_seen = 0;
        ks = '{4'hF, 4'd7, 4'hC, 4'd6, 4'hB, 4'd2, 4'hE, 4'd0};
        ds = '{16'd0, 16'd7, 16'd7, 16'd6, 16'd42, 16'd2, 16'd40, 16'd0};
        run_seq("chain", 7);
        chk("chain_pulses", 32'(rv_seen), 32'd2);

        rv_seen = 0;
        ks = '{4'hF, 4'd5, 4'hA, 4'd3, 4'hE, 4'hE, 4'd0, 4'd0};
        ds = '{16'd0, 16'd5, 16'd5, 16'd3, 16'd8, 16'd11, 16'd0, 16'd0};
        run_seq("repeq", 6);
        chk("repeq_pulses", 32'(rv_seen), 32'd2);
        chk("repeq_B", 32'(alu_B), 32'd3);

        ks = '{4'hF, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'hF};
        ds = '{16'd0, 16'd1, 16'd12, 16'd123, 16'd1234, 16'd12345, 16'd12345, 16'd0};
        run_seq("maxdig", 8);
        ks = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd0, 4'd0, 4'd0};
        ds = '{16'd9, 16'd99, 16'd999, 16'd9999, 16'd34463, 16'd0, 16'd0, 16'd0};
        run_seq("wrap", 5);

`ifdef DIV_ZERO_CHECK_EN
        ks = '{4'hF, 4'd9, 4'hD, 4'd0, 4'hE, 4'd3, 4'd0, 4'd0};
        ds = '{16'd0, 16'd9, 16'd9, 16'd0, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0};
        run_seq("divz", 6);
        chk("divz_err", 32'(err), 32'd1);
        send_key(4'hF);
        chk("divz_clr_err", 32'(err), 32'd0);
        chk("divz_clr_disp", 32'(disp), 32'd0);
        chk("divz_clr_state", 32'(entry_state), 32'd0);
`endif

        ks = '{4'hF, 4'd4, 4'hA, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0};
        ds = '{16'd0, 16'd4, 16'd4, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0};
        run_seq("prerst", 4);
        @(posedge clk);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        rv_seen = 0;
        ks = '{4'd3, 4'hE, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        ds = '{16'd3, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        run_seq("postrst", 2);
        chk("postrst_pulses", 32'(rv_seen), 32'd0);
        chk("postrst_state", 32'(entry_state), 32'd0);

        repeat (3) @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
